// File: rtl/rom_loader.sv
// ROM download writer: packs ioctl bytes into 32-bit little-endian words, queues them
// in a small FIFO and writes each one to SDRAM over the req/ack handshake.
module rom_loader #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        sdram_ready,
    input  logic        sdram_ack,
    output logic        sdram_req,
    output logic        sdram_we,
    output logic [22:0] sdram_addr,
    output logic [31:0] sdram_din,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = 23 + 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    logic            dl_reg;
    logic [31:0]     asm_data_reg,  asm_data_next;
    logic [3:0]      asm_mask_reg,  asm_mask_next;
    logic [22:0]     asm_addr_reg,  asm_addr_next;
    logic [EW-1:0]   fifo_mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg,    wr_ptr_next;
    logic [AW-1:0]   rd_ptr_reg,    rd_ptr_next;
    logic [AW:0]     count_reg,     count_next;
    state_t          state_reg,     state_next;
    logic [22:0]     sdram_addr_reg;
    logic [31:0]     sdram_din_reg;
    logic            overflow_reg,  overflow_next;
    logic            done_reg;

    // ---------------------------------------------------------------
    // Byte assembly
    // ---------------------------------------------------------------
    logic            accept;
    logic            dl_fall;
    logic            dl_rise;
    logic [22:0]     acc_wa;
    logic [1:0]      lane;
    logic            has_asm;
    logic            same_word;
    logic            addr_change;
    logic            flush;
    logic            complete;
    logic [31:0]     base_data;
    logic [3:0]      base_mask;
    logic [31:0]     merged_data;
    logic [3:0]      merged_mask;

    assign accept      = ioctl_wr & ioctl_download;
    assign dl_fall     = dl_reg & ~ioctl_download;
    assign dl_rise     = ~dl_reg & ioctl_download;
    assign acc_wa      = ioctl_addr[24:2];
    assign lane        = ioctl_addr[1:0];
    assign has_asm     = |asm_mask_reg;
    assign same_word   = has_asm && (acc_wa == asm_addr_reg);
    assign addr_change = accept & has_asm & ~same_word;
    assign flush       = dl_fall & has_asm;
    assign complete    = accept & (lane == 2'd3);

    // A byte for a different word starts from an all-zero assembly.
    assign base_data = same_word ? asm_data_reg : 32'd0;
    assign base_mask = same_word ? asm_mask_reg : 4'd0;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_data[gi*8 +: 8] = (lane == 2'(gi)) ? ioctl_data : base_data[gi*8 +: 8];
            assign merged_mask[gi]        = (lane == 2'(gi)) | base_mask[gi];
        end
    endgenerate

    always_comb begin
        asm_data_next = asm_data_reg;
        asm_mask_next = asm_mask_reg;
        asm_addr_next = asm_addr_reg;
        if (accept) begin
            asm_addr_next = acc_wa;
            if (complete) begin
                asm_data_next = 32'd0;
                asm_mask_next = 4'd0;
            end else begin
                asm_data_next = merged_data;
                asm_mask_next = merged_mask;
            end
        end else if (flush) begin
            asm_data_next = 32'd0;
            asm_mask_next = 4'd0;
        end
    end

    // ---------------------------------------------------------------
    // FIFO push side: an address change on a lane-3 byte yields two words at once
    // ---------------------------------------------------------------
    logic            push_old;
    logic [1:0]      n_push;
    logic [EW-1:0]   entry0;
    logic [EW-1:0]   entry1;
    logic [AW+1:0]   space;
    logic            acc0;
    logic            acc1;
    logic [1:0]      n_acc;
    logic            drop;
    logic            pop;
    logic            latch;
    logic [EW-1:0]   head;

    assign push_old = flush | addr_change;
    assign n_push   = {1'b0, push_old} + {1'b0, complete};
    assign entry0   = push_old ? {asm_addr_reg, asm_data_reg} : {acc_wa, merged_data};
    assign entry1   = {acc_wa, merged_data};
    assign space    = (AW+2)'(DEPTH) - (AW+2)'(count_reg) + (AW+2)'(pop);
    assign acc0     = (n_push != 2'd0) && (space != '0);
    assign acc1     = (n_push == 2'd2) && (space >= (AW+2)'(2));
    assign n_acc    = {1'b0, acc0} + {1'b0, acc1};
    assign drop     = ((n_push != 2'd0) && !acc0) || ((n_push == 2'd2) && !acc1);
    assign head     = fifo_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (acc0) fifo_mem[wr_ptr_reg] <= entry0;
        if (acc1) fifo_mem[wr_ptr_reg + AW'(1)] <= entry1;
    end

    always_comb begin
        wr_ptr_next   = wr_ptr_reg + AW'(n_acc);
        rd_ptr_next   = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
        count_next    = count_reg + (AW+1)'(n_acc) - (AW+1)'(pop);
        overflow_next = (overflow_reg & ~dl_rise) | drop;
    end

    // ---------------------------------------------------------------
    // Write FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if ((count_reg != '0) && sdram_ready) state_next = ST_REQ;
            ST_REQ:  if (sdram_ack) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        sdram_req = (state_reg == ST_REQ);
        sdram_we  = (state_reg == ST_REQ);
        latch     = (state_reg == ST_IDLE) && (state_next == ST_REQ);
        pop       = (state_reg == ST_REQ) && sdram_ack;
    end

    // ---------------------------------------------------------------
    // Status: busy and its registered falling-edge pulse line up on the same edge
    // ---------------------------------------------------------------
    logic busy_next;

    assign busy      = dl_reg | (count_reg != '0) | has_asm | (state_reg == ST_REQ);
    assign busy_next = ioctl_download | (count_next != '0) | (asm_mask_next != 4'd0)
                     | (state_next == ST_REQ);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dl_reg         <= 1'b0;
            asm_data_reg   <= 32'd0;
            asm_mask_reg   <= 4'd0;
            asm_addr_reg   <= 23'd0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            sdram_addr_reg <= 23'd0;
            sdram_din_reg  <= 32'd0;
            overflow_reg   <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            dl_reg         <= ioctl_download;
            asm_data_reg   <= asm_data_next;
            asm_mask_reg   <= asm_mask_next;
            asm_addr_reg   <= asm_addr_next;
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            overflow_reg   <= overflow_next;
            done_reg       <= busy & ~busy_next;
            if (latch) begin
                sdram_addr_reg <= head[EW-1:32];
                sdram_din_reg  <= head[31:0];
            end
        end
    end

    assign sdram_addr = sdram_addr_reg;
    assign sdram_din  = sdram_din_reg;
    assign overflow   = overflow_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_rom_loader.sv
// Directed and randomized bench for rom_loader; a byte-level model predicts the
// SDRAM write sequence and a simple req/ack responder plays the controller.
module tb_rom_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic        sdram_ready = 1'b1;
    logic        sdram_ack = 1'b0;
    logic        sdram_req;
    logic        sdram_we;
    logic [22:0] sdram_addr;
    logic [31:0] sdram_din;
    logic        busy;
    logic        done;
    logic        overflow;

    always #5 clk = ~clk;

    rom_loader #(.DEPTH(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .sdram_ready    (sdram_ready),
        .sdram_ack      (sdram_ack),
        .sdram_req      (sdram_req),
        .sdram_we       (sdram_we),
        .sdram_addr     (sdram_addr),
        .sdram_din      (sdram_din),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow)
    );

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          ack_lat = 0;
    bit          stall = 0;
    int          req_age = 0;
    logic [54:0] exp_q[$];
    logic [54:0] last_wr = '0;

    // Model of the assembly: bytes per lane, lane-written flags, word address.
    int          m_wa = 0;
    logic [7:0]  m_b[4];
    bit          m_v[4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic bit m_any();
        return m_v[0] | m_v[1] | m_v[2] | m_v[3];
    endfunction

    task automatic m_push_clear();
        logic [31:0] w;
        w = 32'(m_b[0]) + (32'(m_b[1]) << 8) + (32'(m_b[2]) << 16) + (32'(m_b[3]) << 24);
        exp_q.push_back({23'(m_wa), w});
        for (int i = 0; i < 4; i++) begin
            m_b[i] = 8'h00;
            m_v[i] = 0;
        end
    endtask

    task automatic m_reset();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            m_b[i] = 8'h00;
            m_v[i] = 0;
        end
        m_wa = 0;
    endtask

    task automatic m_accept(input int addr, input logic [7:0] data);
        int wa;
        int ln;
        wa = addr / 4;
        ln = addr % 4;
        if (m_any() && wa != m_wa) m_push_clear();
        m_wa = wa;
        m_b[ln] = data;
        m_v[ln] = 1;
        if (ln == 3) m_push_clear();
    endtask

    // One clock: sample 1 time unit after the edge, then act as the controller.
    task automatic tick();
        @(posedge clk);
        #1;
        if (done) done_cnt++;
        sdram_ack = 1'b0;
        if (sdram_req && !stall) begin
            if (req_age >= ack_lat) begin
                sdram_ack = 1'b1;
                req_age = 0;
                last_wr = {sdram_addr, sdram_din};
                $display("write addr %06h din %08h", sdram_addr, sdram_din);
                check("wr_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) check("wr_word", 64'(last_wr), 64'(exp_q.pop_front()));
            end else begin
                req_age++;
            end
        end else begin
            req_age = 0;
        end
    endtask

    task automatic send_byte(input int addr, input logic [7:0] data, input int gap);
        ioctl_addr = 25'(addr);
        ioctl_data = data;
        ioctl_wr   = 1'b1;
        if (ioctl_download) m_accept(addr, data);
        tick();
        ioctl_wr = 1'b0;
        for (int i = 1; i < gap; i++) tick();
    endtask

    task automatic start_dl();
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        if (m_any()) m_push_clear();
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        check("drain_timeout", 64'(n < 400), 64'd1);
        tick();
        tick();
        check("drain_exp_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int d0;
        int a;
        int stable;
        m_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 64'(sdram_req), 64'd0);
        check("rst_we", 64'(sdram_we), 64'd0);
        check("rst_addr", 64'(sdram_addr), 64'd0);
        check("rst_din", 64'(sdram_din), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        reset_n = 1'b1;
        tick();

        // Sequential 8-byte download
        d0 = done_cnt;
        ack_lat = 3;
        start_dl();
        for (int i = 0; i < 8; i++) send_byte(i, 8'(i), 8);
        end_dl();
        drain();
        check("seq_last", 64'(last_wr), 64'({23'd1, 32'h07060504}));
        check("seq_done", 64'(done_cnt - d0), 64'd1);
        check("seq_ovf", 64'(overflow), 64'd0);

        // Partial tail
        d0 = done_cnt;
        ack_lat = 1;
        start_dl();
        for (int i = 0; i < 6; i++) send_byte(i, 8'(8'hA0 + i), 3);
        end_dl();
        drain();
        check("tail_last", 64'(last_wr), 64'({23'd1, 32'h0000A5A4}));
        check("tail_done", 64'(done_cnt - d0), 64'd1);

        // Address jump
        d0 = done_cnt;
        ack_lat = 0;
        start_dl();
        send_byte(32'h10, 8'h11, 4);
        send_byte(32'h20, 8'h22, 4);
        end_dl();
        drain();
        check("jump_last", 64'(last_wr), 64'({23'd8, 32'h00000022}));
        check("jump_done", 64'(done_cnt - d0), 64'd1);

        // Byte strobe with download low is ignored
        send_byte(32'h3, 8'h5A, 4);
        check("ign_busy", 64'(busy), 64'd0);

        // Stalled controller: six words into a four-deep FIFO
        d0 = done_cnt;
        stall = 1;
        start_dl();
        for (int i = 0; i < 24; i++) send_byte(i, 8'(8'h30 + i), 2);
        // Nothing popped, so words 0..3 occupy the FIFO and words 4 and 5 are lost.
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        stable = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (sdram_req && sdram_we && sdram_addr == 23'd0 && sdram_din == 32'h33323130) stable++;
        end
        check("stall_hold", 64'(stable), 64'd200);
        check("stall_ovf", 64'(overflow), 64'd1);
        stall = 0;
        ack_lat = 1;
        end_dl();
        drain();
        check("stall_last", 64'(last_wr), 64'({23'd3, 32'h3F3E3D3C}));
        check("stall_done", 64'(done_cnt - d0), 64'd1);

        // Not ready
        d0 = done_cnt;
        sdram_ready = 1'b0;
        start_dl();
        check("rise_clears_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 4; i++) send_byte(32'h40 + i, 8'(8'hC0 + i), 4);
        end_dl();
        repeat (5) tick();
        check("nrdy_req", 64'(sdram_req), 64'd0);
        check("nrdy_busy", 64'(busy), 64'd1);
        sdram_ready = 1'b1;
        tick();
        check("rdy_req", 64'(sdram_req), 64'd1);
        drain();
        check("rdy_last", 64'(last_wr), 64'({23'h10, 32'hC3C2C1C0}));
        check("rdy_done", 64'(done_cnt - d0), 64'd1);

        // Randomized downloads
        for (int r = 0; r < 4; r++) begin
            d0 = done_cnt;
            ack_lat = int'($urandom_range(0, 2));
            start_dl();
            a = int'($urandom_range(0, 255));
            for (int i = 0; i < 24; i++) begin
                if ($urandom_range(0, 3) == 0) a = int'($urandom_range(0, 32'h1FFFFFF));
                else a = (a + 1) % 32'h2000000;
                send_byte(a, 8'($urandom), 8);
            end
            end_dl();
            drain();
            check("rnd_done", 64'(done_cnt - d0), 64'd1);
            check("rnd_ovf", 64'(overflow), 64'd0);
        end

        // Reset mid-operation
        stall = 1;
        start_dl();
        for (int i = 0; i < 4; i++) send_byte(i, 8'(8'h90 + i), 2);
        tick();
        check("mid_req_before", 64'(sdram_req), 64'd1);
        reset_n = 1'b0;
        #2;
        check("mid_req", 64'(sdram_req), 64'd0);
        check("mid_we", 64'(sdram_we), 64'd0);
        check("mid_addr", 64'(sdram_addr), 64'd0);
        check("mid_din", 64'(sdram_din), 64'd0);
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_done", 64'(done), 64'd0);
        check("mid_ovf", 64'(overflow), 64'd0);
        ioctl_download = 1'b0;
        stall = 0;
        m_reset();
        tick();
        reset_n = 1'b1;
        d0 = done_cnt;
        sdram_ack = 1'b1;
        repeat (4) tick();
        check("post_rst_req", 64'(sdram_req), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_done", 64'(done_cnt - d0), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
# rom_loader

ROM download writer between the HPS ioctl download stream and the SDRAM controller's request port. It assembles the 8-bit ioctl bytes into 32-bit little-endian words and buffers them in a small FIFO. It then writes each word to SDRAM with the req/ack handshake, so `game` finds the ROM image in SDRAM once `ioctl_download` falls. The block runs in the `clk_sys` domain alongside `sdram`.

## Interface
- DEPTH, 4, word FIFO depth; power of two, minimum 2
- clk  in  1  system clock (`clk_sys`, 48 MHz)
- reset_n  in  1  asynchronous, active-low reset
- ioctl_download  in  1  download in progress
- ioctl_wr  in  1  byte strobe, one cycle per byte
- ioctl_addr  in  25  byte address
- ioctl_data  in  8  byte value
- sdram_ready  in  1  controller initialised
- sdram_ack  in  1  request accepted, one-cycle pulse
- sdram_req  out  1  write request
- sdram_we  out  1  write enable; 1 whenever `sdram_req` is 1
- sdram_addr  out  23  word address (`ioctl_addr[24:2]`)
- sdram_din  out  32  write data
- busy  out  1  download active, data buffered, or write outstanding
- done  out  1  one-cycle pulse when the download has fully landed in SDRAM
- overflow  out  1  sticky: a word was dropped because the FIFO was full

## Operation
- Assembly register: 32-bit data, 4-bit lane-valid mask, 23-bit word address.
- Byte lane mapping: lane = `ioctl_addr[1:0]`. Lane 0 maps to bits 7:0 and lane 3 to bits 31:24.
- Accepted byte: `ioctl_wr` & `ioctl_download`. An `ioctl_wr` pulse with `ioctl_download` low is ignored.
- Word address change: if an accepted byte's `ioctl_addr[24:2]` differs from the assembly address and the mask is non-zero, the current assembly is pushed first as a partial word. Lanes that were never written are 0x00. The new byte then starts a fresh assembly.
- Full word: an accepted byte on lane 3 completes the word. The assembly, including that byte, is pushed and the mask is cleared in the same cycle.
- Flush: on the falling edge of `ioctl_download`, a non-empty assembly is pushed as a partial word (zero-padded).
- Rising edge of `ioctl_download`: clears `overflow`. The FIFO and the assembly register are not cleared.
- Overflow: a push while the FIFO holds DEPTH entries, with no pop in the same cycle, drops the word and sets `overflow`. A push and a pop in the same cycle always succeed.
- Write FSM:
  - IDLE: when the FIFO is non-empty and `sdram_ready` is 1, latch the head entry into `sdram_addr`/`sdram_din`, set `sdram_req`=`sdram_we`=1, and go to REQ.
  - REQ: hold `sdram_req`, `sdram_we`, `sdram_addr` and `sdram_din` stable until `sdram_ack`. In the ack cycle, pop the FIFO. Next cycle: `sdram_req`=0 and the FSM returns to IDLE.
- `busy` = `ioctl_download` | FIFO non-empty | assembly mask non-zero | state==REQ.
- `done`: pulses for one cycle on the first cycle in which `busy` falls from 1 to 0.

## Timing
- Reset values: `sdram_req`=0, `sdram_we`=0, `sdram_addr`=0, `sdram_din`=0, `busy`=0, `done`=0, `overflow`=0. The FIFO is empty, the mask is 0, and the FSM is in IDLE.
- Assertion of `reset_n` low mid-transfer drops `sdram_req` immediately, without waiting for a clock edge. An outstanding `sdram_ack` after reset is ignored.
- Latency:
  - The push is registered at the edge that samples the lane-3 `ioctl_wr`.
  - `sdram_req` rises at the following edge, provided the FSM is in IDLE and `sdram_ready` is 1.
- Minimum spacing between consecutive write requests: 2 cycles (one REQ/ack cycle plus one IDLE cycle).
- `done` is asserted at the edge at which the final pop completes, or at which the falling-edge flush leaves nothing pending.
- Address wrap: `ioctl_addr` bits above 24 do not exist. `sdram_addr` is exactly `ioctl_addr[24:2]` with no offset.

## Test plan
- Sequential 8-byte download: bytes 0x00..0x07 at addresses 0..7, with ioctl_wr 1 cycle in every 8 and `sdram_ack` 3 cycles after req. Required: two writes, addr 0 din 0x03020100 and addr 1 din 0x07060504. `done` pulses once after the second ack; `overflow`=0.
- Partial tail: 6 bytes 0xA0..0xA5 at addresses 0..5, then `ioctl_download` falls. Required second write: addr 1, din 0x0000A5A4.
- Stalled controller: `sdram_ack` held low for 200 cycles while 6 full words arrive with DEPTH=4. Required: `overflow`=1, and the 5th and 6th words are absent from the write sequence. The first word (addr 0) stays on `sdram_addr`/`sdram_din` with req high for the whole 200 cycles.
- Address jump: byte 0x11 at address 0x10, then byte 0x22 at address 0x20. Required: write addr 4 din 0x00000011, then after the flush, addr 8 din 0x00000022.
- Reset mid-operation: `reset_n` pulled low while `sdram_req`=1. Required: `sdram_req`=0 before the next clk edge and all outputs at their reset values. A later ack produces no pop and no `done`.
- Not ready: `sdram_ready`=0 through a 4-byte download. Required: no req and `busy`=1. `sdram_req` rises 1 cycle after `sdram_ready` rises.
